// File: rtl/aq_pkg.sv
// Shared CAQ definitions: parser states, tape-format constants and the
// default memory map of the quick-load controller.
package aq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC1 = 3'd1,
        NAME  = 3'd2,
        SYNC2 = 3'd3,
        DATA  = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_e;

    localparam logic [7:0]  SYNC_BYTE = 8'hFF;
    localparam logic [7:0]  SYNC_END  = 8'h00;
    localparam int          NAME_LEN  = 6;

    localparam logic [15:0] LOAD_BASE_DEF = 16'h3901;
    localparam logic [15:0] RAM_TOP_DEF   = 16'h7FFF;
    localparam int unsigned SYNC_MIN_DEF  = 6;
    localparam int unsigned ZERO_RUN_DEF  = 3;

    // A load is in progress whenever the parser sits in one of the
    // byte-consuming states.
    function automatic logic is_parse_state(input state_e s);
        return (s == SYNC1) || (s == NAME) || (s == SYNC2) || (s == DATA);
    endfunction

endpackage

// File: rtl/caq_quickload_if.sv
// Tape RAM read port and main RAM write port seen by the quick loader.
interface caq_quickload_if;
    logic [15:0] tape_addr;
    logic [7:0]  tape_data;
    logic        ram_sel;
    logic [15:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_we;

    modport master (
        output tape_addr,
        input  tape_data,
        output ram_sel,
        output ram_addr,
        output ram_dout,
        output ram_we
    );

    modport slave (
        input  tape_addr,
        output tape_data,
        input  ram_sel,
        input  ram_addr,
        input  ram_dout,
        input  ram_we
    );
endinterface

// File: rtl/caq_write_sched.sv
// Pending-write register plus ce-gap arbiter: a queued byte is put on the
// main RAM port only on a clk_sys cycle the CPU does not own (ce=0).
module caq_write_sched (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        push_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  data_i,
    output logic        ram_sel_o,
    output logic        ram_we_o,
    output logic [15:0] ram_addr_o,
    output logic [7:0]  ram_dout_o,
    output logic        stall_o
);

    logic        pend_q, pend_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        issue;

    // Issue on the first free cycle; a new push reloads the holding register.
    always_comb begin
        issue  = pend_q & ~ce;
        pend_d = pend_q & ~issue;
        addr_d = addr_q;
        data_d = data_q;
        if (push_i) begin
            pend_d = 1'b1;
            addr_d = addr_i;
            data_d = data_i;
        end
    end

    // Holding register; reset drops any queued write so nothing is issued.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pend_q <= 1'b0;
            addr_q <= 16'h0000;
            data_q <= 8'h00;
        end else begin
            pend_q <= pend_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign ram_sel_o  = issue;
    assign ram_we_o   = issue;
    assign ram_addr_o = addr_q;
    assign ram_dout_o = data_q;
    // The parser may only move on once the queued byte leaves this cycle.
    assign stall_o    = pend_q & ce;

endmodule

// File: rtl/caq_quickload.sv
// CAQ fast loader: walks a tape image in tape RAM (leader, name, leader,
// program body) and copies the body into main RAM in CPU-idle cycles.
module caq_quickload
    import aq_pkg::*;
#(
    parameter logic [15:0] LOAD_BASE = LOAD_BASE_DEF,
    parameter logic [15:0] RAM_TOP   = RAM_TOP_DEF,
    parameter int unsigned SYNC_MIN  = SYNC_MIN_DEF,
    parameter int unsigned ZERO_RUN  = ZERO_RUN_DEF
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            ce,
    input  logic            start,
    input  logic [15:0]     length,
    caq_quickload_if.master bus,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [15:0]     end_addr,
    output logic [47:0]     name
);

    localparam logic [7:0] SYNC_MIN_B = 8'(SYNC_MIN);
    localparam logic [7:0] ZERO_RUN_B = 8'(ZERO_RUN);
    localparam logic [7:0] NAME_LAST  = 8'(NAME_LEN - 1);

    state_e      state_q, state_d;
    logic        use_q, use_d;          // 0: FETCH (address out), 1: USE (data in)
    logic [15:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] len_q, len_d;
    logic [16:0] wr_ptr_q, wr_ptr_d;    // extra bit so running past 16'hFFFF cannot wrap
    logic [7:0]  cnt_q, cnt_d;          // leader length or name byte index
    logic [7:0]  zero_q, zero_d;
    logic [47:0] name_q, name_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [15:0] end_addr_q, end_addr_d;
    logic        push;
    logic        stall;
    logic [7:0]  tbyte;

    assign tbyte = bus.tape_data;

    // Parser next-state: one byte per FETCH/USE pair, DATA bytes queued as writes.
    always_comb begin
        state_d    = state_q;
        use_d      = use_q;
        rd_ptr_d   = rd_ptr_q;
        len_d      = len_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        zero_d     = zero_q;
        name_d     = name_q;
        done_d     = done_q;
        error_d    = error_q;
        end_addr_d = end_addr_q;
        push       = 1'b0;

        if (!is_parse_state(state_q)) begin
            if (start) begin
                done_d = 1'b0;
                if (length != 16'h0000) begin
                    state_d  = SYNC1;
                    error_d  = 1'b0;
                    name_d   = 48'h0;
                    use_d    = 1'b0;
                    rd_ptr_d = 16'h0000;
                    len_d    = length;
                    wr_ptr_d = {1'b0, LOAD_BASE};
                    cnt_d    = 8'h00;
                    zero_d   = 8'h00;
                end else begin
                    state_d = ERR;
                    error_d = 1'b1;
                end
            end
        end else if (!use_q) begin
            // FETCH: the last queued byte must be on its way before anything else.
            if (state_q == DATA && stall) begin
                use_d = 1'b0;
            end else if (state_q == DATA && zero_q >= ZERO_RUN_B) begin
                state_d    = DONE;
                done_d     = 1'b1;
                end_addr_d = wr_ptr_q[15:0];
            end else if (rd_ptr_q == len_q) begin
                if (state_q == DATA) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    end_addr_d = wr_ptr_q[15:0];
                end else begin
                    state_d = ERR;
                    error_d = 1'b1;
                end
            end else begin
                use_d = 1'b1;
            end
        end else begin
            use_d    = 1'b0;
            rd_ptr_d = rd_ptr_q + 16'd1;
            case (state_q)
                SYNC1, SYNC2: begin
                    if (tbyte == SYNC_BYTE) begin
                        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                    end else if (tbyte == SYNC_END && cnt_q >= SYNC_MIN_B) begin
                        state_d = (state_q == SYNC1) ? NAME : DATA;
                        cnt_d   = 8'h00;
                        zero_d  = 8'h00;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
                NAME: begin
                    name_d = {name_q[39:0], tbyte};
                    if (cnt_q == NAME_LAST) begin
                        state_d = SYNC2;
                        cnt_d   = 8'h00;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                DATA: begin
                    if (wr_ptr_q > {1'b0, RAM_TOP}) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else begin
                        push     = 1'b1;
                        wr_ptr_d = wr_ptr_q + 17'd1;
                        zero_d   = (tbyte == 8'h00) ? zero_q + 8'd1 : 8'h00;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Parser state, pointers and sticky status registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            use_q      <= 1'b0;
            rd_ptr_q   <= 16'h0000;
            len_q      <= 16'h0000;
            wr_ptr_q   <= 17'h00000;
            cnt_q      <= 8'h00;
            zero_q     <= 8'h00;
            name_q     <= 48'h0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            end_addr_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            use_q      <= use_d;
            rd_ptr_q   <= rd_ptr_d;
            len_q      <= len_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            zero_q     <= zero_d;
            name_q     <= name_d;
            done_q     <= done_d;
            error_q    <= error_d;
            end_addr_q <= end_addr_d;
        end
    end

    caq_write_sched u_sched (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ce         (ce),
        .push_i     (push),
        .addr_i     (wr_ptr_q[15:0]),
        .data_i     (tbyte),
        .ram_sel_o  (bus.ram_sel),
        .ram_we_o   (bus.ram_we),
        .ram_addr_o (bus.ram_addr),
        .ram_dout_o (bus.ram_dout),
        .stall_o    (stall)
    );

    assign bus.tape_addr = rd_ptr_q;
    assign busy          = is_parse_state(state_q);
    assign done          = done_q;
    assign error         = error_q;
    assign end_addr      = end_addr_q;
    assign name          = name_q;

endmodule

// File: doc/caq_quickload.md
# caq_quickload

Fast-load controller that parses a CAQ tape image already held in tape RAM and copies the program body directly into main RAM, bypassing the 3.33 kHz bit-serial tape path. It sits between tape RAM port B, the main RAM CPU port and the CPU clock-enable, and schedules its RAM writes into clk_sys cycles the CPU does not use, so the CPU keeps running during the load. Status and the parsed file name go to the OSD/top level.

## Interface
- LOAD_BASE, 16'h3901: main RAM address of the first program byte.
- RAM_TOP, 16'h7FFF: highest writable address; a write beyond it is an error.
- SYNC_MIN, 6: minimum consecutive 0xFF bytes accepted as a sync leader.
- ZERO_RUN, 3: consecutive 0x00 data bytes that mark end of program.

- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- ce  in  1  CPU clock-enable (ce_3m5); CPU owns the RAM port on cycles where ce=1
- start  in  1  one-cycle pulse that begins a load
- length  in  16  tape image byte count
- tape_addr  out  16  tape RAM read address
- tape_data  in  8  tape RAM data, valid 1 clk_sys after tape_addr
- ram_sel  out  1  1 = loader drives main RAM port this cycle
- ram_addr  out  16  main RAM write address
- ram_dout  out  8  main RAM write data
- ram_we  out  1  main RAM write strobe
- busy  out  1  load in progress
- done  out  1  sticky success flag
- error  out  1  sticky failure flag
- end_addr  out  16  address one past the last written byte
- name  out  48  6-byte file name, first character in [47:40]

## Operation
- States: IDLE, SYNC1, NAME, SYNC2, DATA, DONE, ERR. Each byte read takes a FETCH cycle (drive tape_addr) and a USE cycle (consume tape_data).
- IDLE: start with length≠0 clears done/error/name, sets rd_ptr=0, moves to SYNC1. start with length=0 goes directly to ERR. start while busy is ignored.
- SYNC1/SYNC2: count consecutive 0xFF bytes.
  - 0x00 with count≥SYNC_MIN: SYNC1 goes to NAME, SYNC2 goes to DATA.
  - 0x00 with count<SYNC_MIN, or any other byte value: ERR.
- NAME: the next 6 bytes are shifted into name, then the state moves to SYNC2.
- DATA: each byte is written to wr_ptr (starting at LOAD_BASE), then wr_ptr increments.
  - zero_run counts consecutive 0x00 bytes and clears on any non-zero byte.
  - When zero_run reaches ZERO_RUN (after that byte is written): DONE, end_addr=wr_ptr.
  - If wr_ptr>RAM_TOP at a pending write: ERR, and that byte is not written.
- End of image: rd_ptr=length in DATA gives DONE with end_addr=wr_ptr. rd_ptr=length in any other parse state gives ERR.
- DONE/ERR: busy=0 and the flag is held. The next valid start restarts.
- reset at any time: IDLE, all counters and pointers 0, no write issued.

## Timing
- Reset values: tape_addr=0, ram_sel=0, ram_addr=0, ram_dout=0, ram_we=0, busy=0, done=0, error=0, end_addr=0, name=0.
- busy rises the cycle after start and falls the cycle done or error rises.
- Tape read latency is 1 cycle, so one byte is consumed per 2 clk_sys cycles.
- A DATA byte becomes a pending write. It is issued on the first clk_sys cycle with ce=0: ram_sel=ram_we=1 for exactly that cycle.
  - ce=1 and pending: the write waits, and parsing of the next byte stalls.
  - ram_sel never overlaps a ce=1 cycle.
- With ce at the 1/16 rate, throughput is about 1 byte per 2–3 clk_sys cycles.
- DONE is entered the cycle after the terminating write is issued. done and end_addr update together.

## Structure
- Shared package aq_pkg holds the state enum and the CAQ constants (SYNC_BYTE=8'hFF, SYNC_END=8'h00, NAME_LEN=6).
- Natural sub-module: caq_write_sched, the pending-write register and ce-gap arbiter that drives ram_sel/ram_we and returns a stall signal.
- The parser FSM stays in caq_quickload.

## Test plan
- Valid image (12×FF, 00, "HELLO ", 12×FF, 00, 41 42 00 00 00), ce every 16th cycle -> bytes 41,42,00,00,00 written to 3901..3905; name="HELLO "; done=1; end_addr=3906; no ram_we while ce=1.
- Short leader (4×FF, 00) -> error=1 after the 00 byte; no ram_we ever.
- Image truncated in DATA (length ends after 41 42) -> done=1, end_addr=3903.
- Image truncated inside NAME -> error=1; done=0.
- LOAD_BASE=7FFE with 4 non-zero data bytes -> 7FFE and 7FFF written; error=1; 8000 not written.
- reset pulsed mid-DATA while a write is pending -> no ram_we after reset; busy=0; a new start loads correctly from rd_ptr=0.
